ysyx_22051013_wb_regfile: RTL

//  Receiving end of the write-back interface: integer register file (x0..x31) written by the WBU

---
 rtl/ysyx_22051013_wb_regfile.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ysyx_22051013_wb_regfile.sv
// Write-back receiving register file: 2 combinational read ports with WB bypass,
// per-register pending-write scoreboard driving RAW stall, sticky retire-underflow flag.
module ysyx_22051013_wb_regfile_pend #(
    parameter int PW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_iss,
    input  logic          i_ret,
    output logic [PW-1:0] o_pend,
    output logic          o_under
);
    logic [PW-1:0] r_pend;

    // Issue and retire to the same register in one cycle cancel out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_pend <= '0;
        else if (i_flush)
            r_pend <= '0;
        else if (i_iss && !i_ret)
            r_pend <= r_pend + PW'(1);
        else if (i_ret && !i_iss && r_pend != '0)
            r_pend <= r_pend - PW'(1);
    end

    assign o_pend  = r_pend;
    assign o_under = i_ret && !i_iss && !i_flush && (r_pend == '0);
endmodule

module ysyx_22051013_wb_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int PW   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wb_rd_ena,
    input  logic [AW-1:0]   i_wb_rd_addr,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_rs1_ena,
    input  logic [AW-1:0]   i_rs1_addr,
    output logic [XLEN-1:0] o_rs1_data,
    input  logic            i_rs2_ena,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_issue_valid,
    input  logic            i_issue_rd_ena,
    input  logic [AW-1:0]   i_issue_rd_addr,
    output logic            o_issue_ready,
    input  logic            i_flush,
    output logic            o_raw_stall,
    output logic            o_sb_err,
    output logic [31:0]     o_wb_count
);
    logic [NREG-1:0][XLEN-1:0] r_regs;
    logic [NREG-1:0][PW-1:0]   w_pend;
    logic [NREG-1:0]           w_under;
    logic                      w_iss;
    logic                      w_ret;
    logic                      r_sb_err;
    logic [31:0]               r_wb_count;

    assign w_ret = i_wb_rd_ena && (i_wb_rd_addr != '0);
    assign w_iss = i_issue_valid && i_issue_rd_ena && (i_issue_rd_addr != '0) && o_issue_ready;

    // A retire in the same cycle does not free a slot for issue.
    assign o_issue_ready = !(i_issue_rd_ena && (w_pend[i_issue_rd_addr] == {PW{1'b1}}));

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_pend
            if (g == 0) begin : g_zero
                assign w_pend[g]  = '0;
                assign w_under[g] = 1'b0;
            end else begin : g_reg
                ysyx_22051013_wb_regfile_pend #(.PW(PW)) u_pend (
                    .i_clk  (i_clk),
                    .i_rst  (i_rst),
                    .i_flush(i_flush),
                    .i_iss  (w_iss && (i_issue_rd_addr == AW'(g))),
                    .i_ret  (w_ret && (i_wb_rd_addr == AW'(g))),
                    .o_pend (w_pend[g]),
                    .o_under(w_under[g])
                );
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_regs     <= '0;
            r_sb_err   <= 1'b0;
            r_wb_count <= '0;
        end else begin
            if (w_ret) begin
                r_regs[i_wb_rd_addr] <= i_wb_data;
                r_wb_count           <= r_wb_count + 32'd1;
            end
            if (|w_under)
                r_sb_err <= 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic ena, input logic [AW-1:0] addr);
        if (!ena || addr == '0)
            return '0;
        else if (i_wb_rd_ena && i_wb_rd_addr == addr)
            return i_wb_data;
        else
            return r_regs[addr];
    endfunction

    // A source whose only outstanding write is retiring now is served by the bypass.
    function automatic logic port_stall(input logic ena, input logic [AW-1:0] addr);
        logic w_hit;
        w_hit = w_ret && (i_wb_rd_addr == addr);
        return ena && (addr != '0) && (w_pend[addr] > PW'(w_hit));
    endfunction

    assign o_rs1_data  = i_rst ? '0 : rd_port(i_rs1_ena, i_rs1_addr);
    assign o_rs2_data  = i_rst ? '0 : rd_port(i_rs2_ena, i_rs2_addr);
    assign o_raw_stall = port_stall(i_rs1_ena, i_rs1_addr) || port_stall(i_rs2_ena, i_rs2_addr);
    assign o_sb_err    = r_sb_err;
    assign o_wb_count  = r_wb_count;
endmodule
